iir_biquad_cascade: RTL and testbench
=====================================

# iir_biquad_cascade

Parametrised cascade of NUM_SECTIONS second-order IIR sections (Direct Form I) sharing a single time-multiplexed multiply-accumulate unit. Coefficients are runtime-writable through a register port. Per-section history state is held internally. Samples enter and leave over valid/ready handshakes. The block sits in the filter datapath between the sample source and downstream consumers, and replaces the single fixed biquad where higher filter orders or runtime retuning are needed.

## Interface
- DATA_WIDTH, 32, sample width, signed two's complement
- COEFF_WIDTH, 32, coefficient width, signed, fixed-point with SCALE_SHIFT fractional bits
- ACC_WIDTH, 72, accumulator width; must be ≥ DATA_WIDTH+COEFF_WIDTH+3
- SCALE_SHIFT, 20, fractional bits of coefficients; must be < COEFF_WIDTH-1
- NUM_SECTIONS, 2, number of cascaded biquads, ≥ 1
- ADDR_WIDTH, $clog2(5*NUM_SECTIONS), coefficient address width
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  input sample valid
- in_ready  out  1  block can accept a sample this cycle
- in_data  in  DATA_WIDTH  input sample
- out_valid  out  1  output sample valid, held until accepted
- out_ready  in  1  consumer accepts output
- out_data  out  DATA_WIDTH  filtered sample
- coef_we  in  1  coefficient write strobe
- coef_addr  in  ADDR_WIDTH  section*5 + index; index 0=b0, 1=b1, 2=b2, 3=a1, 4=a2
- coef_wdata  in  COEFF_WIDTH  coefficient value
- state_clr  in  1  zero all section histories
- sat_flag  out  1  sticky saturation indicator; see Configuration

## Operation
- Each section computes y[n] = (b0·x[n] + b1·x[n-1] + b2·x[n-2] − a1·y[n-1] − a2·y[n-2]) >>> SCALE_SHIFT.
- The shift is arithmetic. The output of section k is the input of section k+1.
- Products are full-width signed (DATA_WIDTH+COEFF_WIDTH), sign-extended, and accumulated in ACC_WIDTH.
- History registers store section input and output samples at DATA_WIDTH, after the scale and narrowing step.
- FSM states:
  - IDLE
  - MAC: 5 cycles per section, index 0..4
  - WB: 1 cycle per section; scale, narrow, update x1/x2/y1/y2, advance section
  - OUT
- IDLE→MAC on accept (in_valid && in_ready). The sample is latched, section=0, idx=0, acc=0.
- MAC→WB after idx 4.
- WB→MAC if section < NUM_SECTIONS-1; otherwise WB→OUT, with out_data and out_valid registered.
- OUT→IDLE on out_valid && out_ready.
- in_ready = (state==IDLE) && !state_clr.
- Coefficient writes:
  - Applied only in IDLE. coef_we in any other state is dropped silently.
  - Addresses ≥ 5*NUM_SECTIONS are ignored.
  - A write in the same cycle as an accept takes effect for that sample.
- state_clr:
  - Honoured only in IDLE, where it zeroes all histories. Ignored in other states.
  - In IDLE it takes priority over accepting a sample, because in_ready is low that cycle.
- Reset values:
  - state=IDLE, all histories 0, acc 0.
  - out_valid=0, out_data=0, sat_flag=0.
  - Coefficients reset to identity: b0=1<<SCALE_SHIFT, all others 0 in every section.
- Reset asserted mid-computation discards the in-flight sample. No output is produced for it.

## Timing
- Accept edge E0. Section k MACs occur on edges E(6k+1)..E(6k+5), and its WB on edge E(6k+6).
- out_valid goes high after edge E(6·NUM_SECTIONS), giving a latency of 6·NUM_SECTIONS cycles.
- out_data is stable while out_valid && !out_ready.
- in_ready rises on the cycle after the output handshake.
- Peak throughput with out_ready tied high: one sample per 6·NUM_SECTIONS+2 cycles.
- in_ready is combinational from state and state_clr only. No other output depends combinationally on inputs.

## Configuration
- Macro: IIR_BIQUAD_SAT_EN.
- Defined:
  - At each WB, the scaled value is clamped to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1] before it is stored and forwarded.
  - Any clamp sets sat_flag. sat_flag is cleared only by rst or by state_clr in IDLE.
- Undefined:
  - The scaled value is truncated to its low DATA_WIDTH bits (wrap-around).
  - sat_flag is tied to 0.

## Test plan
- Reset, NUM_SECTIONS=2, in_data=1000 with out_ready=1 → out_data=1000 with out_valid high exactly 12 cycles after accept; in_ready low throughout.
- Write section0 b0=1<<19, then in_data=1000 → out_data=500. Then coef_we during MAC with b0=0 → write dropped, and the next sample of 1000 → 500.
- Section0 b0=1<<20, a1=−(1<<19); section1 identity. Impulse 1024 followed by zeros → out_data 1024, 512, 256, 128, 64.
- Hold out_ready=0 for 10 cycles after out_valid → out_data stable, in_ready=0, in_valid sample not accepted. Raise out_ready → handshake, then in_ready=1 on the next cycle.
- Section0 b0=4<<20, in_data=2^30:
  - With IIR_BIQUAD_SAT_EN → out_data=2^31−1 and sat_flag=1.
  - Without the macro → out_data=0 and sat_flag=0.
- After an impulse with the tail still nonzero, pulse state_clr in IDLE → the next sample of 0 gives out_data=0, and sat_flag is cleared. Assert rst mid-MAC → no out_valid, all outputs at their reset values.

Source files
------------

// File: rtl/iir_biquad_cascade_if.sv
// Sample, coefficient and status signals of iir_biquad_cascade.
// master drives samples/coefficients, slave is the filter.
interface iir_biquad_cascade_if #(
    parameter int DATA_WIDTH   = 32,
    parameter int COEFF_WIDTH  = 32,
    parameter int NUM_SECTIONS = 2,
    parameter int ADDR_WIDTH   = $clog2(5 * NUM_SECTIONS)
) ();
    logic                   in_valid;
    logic                   in_ready;
    logic [DATA_WIDTH-1:0]  in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [DATA_WIDTH-1:0]  out_data;
    logic                   coef_we;
    logic [ADDR_WIDTH-1:0]  coef_addr;
    logic [COEFF_WIDTH-1:0] coef_wdata;
    logic                   state_clr;
    logic                   sat_flag;

    modport master (
        output in_valid, in_data, out_ready, coef_we, coef_addr, coef_wdata, state_clr,
        input  in_ready, out_valid, out_data, sat_flag
    );

    modport slave (
        input  in_valid, in_data, out_ready, coef_we, coef_addr, coef_wdata, state_clr,
        output in_ready, out_valid, out_data, sat_flag
    );
endinterface

// File: rtl/iir_biquad_cascade.sv
// Cascade of Direct Form I biquads sharing one multiply-accumulate unit.
// Optional output clamping and sticky sat_flag: define IIR_BIQUAD_SAT_EN.
module iir_biquad_cascade #(
    parameter int DATA_WIDTH   = 32,
    parameter int COEFF_WIDTH  = 32,
    parameter int ACC_WIDTH    = 72,
    parameter int SCALE_SHIFT  = 20,
    parameter int NUM_SECTIONS = 2,
    parameter int ADDR_WIDTH   = $clog2(5 * NUM_SECTIONS)
) (
    input  logic                 clk,
    input  logic                 rst,
    iir_biquad_cascade_if.slave  bus
);
    localparam int PROD_WIDTH = DATA_WIDTH + COEFF_WIDTH;
    localparam int NUM_COEFS  = 5 * NUM_SECTIONS;
    localparam int SEC_WIDTH  = (NUM_SECTIONS > 1) ? $clog2(NUM_SECTIONS) : 1;
    localparam logic signed [COEFF_WIDTH-1:0] COEF_ONE =
        {{(COEFF_WIDTH-1){1'b0}}, 1'b1} << SCALE_SHIFT;
`ifdef IIR_BIQUAD_SAT_EN
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_WB   = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    // Returns {clamped, sample}: scaled accumulator narrowed to DATA_WIDTH.
    function automatic logic [DATA_WIDTH:0] narrow_sample(input logic signed [ACC_WIDTH-1:0] v);
`ifdef IIR_BIQUAD_SAT_EN
        if (v > SAT_MAX) begin
            return {1'b1, 1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else if (v < SAT_MIN) begin
            return {1'b1, 1'b1, {(DATA_WIDTH-1){1'b0}}};
        end else begin
            return {1'b0, v[DATA_WIDTH-1:0]};
        end
`else
        return {1'b0, v[DATA_WIDTH-1:0]};
`endif
    endfunction

    state_t                         state_r, state_s;
    logic [SEC_WIDTH-1:0]           sec_r;
    logic [2:0]                     idx_r;
    logic signed [ACC_WIDTH-1:0]    acc_r;
    logic signed [DATA_WIDTH-1:0]   cur_x_r;
    logic signed [COEFF_WIDTH-1:0]  coef_r [NUM_COEFS];
    logic signed [DATA_WIDTH-1:0]   x1_r [NUM_SECTIONS];
    logic signed [DATA_WIDTH-1:0]   x2_r [NUM_SECTIONS];
    logic signed [DATA_WIDTH-1:0]   y1_r [NUM_SECTIONS];
    logic signed [DATA_WIDTH-1:0]   y2_r [NUM_SECTIONS];
    logic                           out_valid_r;
    logic [DATA_WIDTH-1:0]          out_data_r;
    logic                           sat_flag_r;

    logic                           in_ready_s;
    logic                           accept_s;
    logic                           coef_wr_s;
    logic                           last_sec_s;
    logic [ADDR_WIDTH-1:0]          coef_idx_s;
    logic signed [DATA_WIDTH-1:0]   operand_s;
    logic signed [COEFF_WIDTH-1:0]  coef_sel_s;
    logic [PROD_WIDTH-1:0]          prod_s;
    logic signed [ACC_WIDTH-1:0]    prod_ext_s;
    logic signed [ACC_WIDTH-1:0]    acc_next_s;
    logic signed [ACC_WIDTH-1:0]    scaled_s;
    logic [DATA_WIDTH:0]            narrow_s;

    assign in_ready_s    = (state_r == ST_IDLE) && !bus.state_clr;
    assign accept_s      = bus.in_valid && in_ready_s;
    assign coef_wr_s     = (state_r == ST_IDLE) && bus.coef_we &&
                           (32'(bus.coef_addr) < 32'(NUM_COEFS));
    assign last_sec_s    = (sec_r == SEC_WIDTH'(NUM_SECTIONS - 1));
    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.sat_flag  = sat_flag_r;

    // Operand and coefficient selection plus the shared MAC and narrowing.
    always_comb begin
        operand_s  = '0;
        coef_idx_s = ADDR_WIDTH'(sec_r) * ADDR_WIDTH'(3'd5) + ADDR_WIDTH'(idx_r);
        case (idx_r)
            3'd0:    operand_s = cur_x_r;
            3'd1:    operand_s = x1_r[sec_r];
            3'd2:    operand_s = x2_r[sec_r];
            3'd3:    operand_s = y1_r[sec_r];
            3'd4:    operand_s = y2_r[sec_r];
            default: operand_s = '0;
        endcase
        coef_sel_s = coef_r[coef_idx_s];
        prod_s     = {{COEFF_WIDTH{operand_s[DATA_WIDTH-1]}}, operand_s} *
                     {{DATA_WIDTH{coef_sel_s[COEFF_WIDTH-1]}}, coef_sel_s};
        prod_ext_s = {{(ACC_WIDTH-PROD_WIDTH){prod_s[PROD_WIDTH-1]}}, prod_s};
        // Feedback taps (a1, a2) are subtracted.
        if (idx_r >= 3'd3) begin
            acc_next_s = acc_r - prod_ext_s;
        end else begin
            acc_next_s = acc_r + prod_ext_s;
        end
        scaled_s = acc_r >>> SCALE_SHIFT;
        narrow_s = narrow_sample(scaled_s);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) state_s = ST_MAC;
                else          state_s = ST_IDLE;
            end
            ST_MAC: begin
                if (idx_r == 3'd4) state_s = ST_WB;
                else               state_s = ST_MAC;
            end
            ST_WB: begin
                if (last_sec_s) state_s = ST_OUT;
                else            state_s = ST_MAC;
            end
            ST_OUT: begin
                if (out_valid_r && bus.out_ready) state_s = ST_IDLE;
                else                              state_s = ST_OUT;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Coefficient bank, reset to an identity filter in every section.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_COEFS; i++) begin
                coef_r[i] <= ((i % 5) == 0) ? COEF_ONE : '0;
            end
        end else if (coef_wr_s) begin
            coef_r[bus.coef_addr] <= bus.coef_wdata;
        end
    end

    // Per-section history, shifted at write-back.
    always_ff @(posedge clk) begin
        if (rst || ((state_r == ST_IDLE) && bus.state_clr)) begin
            for (int i = 0; i < NUM_SECTIONS; i++) begin
                x1_r[i] <= '0;
                x2_r[i] <= '0;
                y1_r[i] <= '0;
                y2_r[i] <= '0;
            end
        end else if (state_r == ST_WB) begin
            x2_r[sec_r] <= x1_r[sec_r];
            x1_r[sec_r] <= cur_x_r;
            y2_r[sec_r] <= y1_r[sec_r];
            y1_r[sec_r] <= narrow_s[DATA_WIDTH-1:0];
        end
    end

    // Sequencing counters, accumulator and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            sec_r       <= '0;
            idx_r       <= 3'd0;
            acc_r       <= '0;
            cur_x_r     <= '0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            sat_flag_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.state_clr) begin
                        sat_flag_r <= 1'b0;
                    end else if (bus.in_valid) begin
                        cur_x_r <= bus.in_data;
                        sec_r   <= '0;
                        idx_r   <= 3'd0;
                        acc_r   <= '0;
                    end
                end
                ST_MAC: begin
                    acc_r <= acc_next_s;
                    idx_r <= (idx_r == 3'd4) ? 3'd0 : idx_r + 3'd1;
                end
                ST_WB: begin
                    cur_x_r    <= narrow_s[DATA_WIDTH-1:0];
                    acc_r      <= '0;
                    sat_flag_r <= sat_flag_r | narrow_s[DATA_WIDTH];
                    if (last_sec_s) begin
                        out_data_r  <= narrow_s[DATA_WIDTH-1:0];
                        out_valid_r <= 1'b1;
                    end else begin
                        sec_r <= sec_r + SEC_WIDTH'(1);
                    end
                end
                ST_OUT: begin
                    if (bus.out_ready) out_valid_r <= 1'b0;
                end
                default: begin
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_iir_biquad_cascade.sv
// Directed bench for iir_biquad_cascade (two sections, 20 fractional bits).
module tb_iir_biquad_cascade;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    iir_biquad_cascade_if #(.DATA_WIDTH(32), .COEFF_WIDTH(32), .NUM_SECTIONS(2)) bus ();

    iir_biquad_cascade #(
        .DATA_WIDTH(32), .COEFF_WIDTH(32), .ACC_WIDTH(72),
        .SCALE_SHIFT(20), .NUM_SECTIONS(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_coef(input logic [3:0] a, input logic [31:0] d);
        bus.coef_we    = 1'b1;
        bus.coef_addr  = a;
        bus.coef_wdata = d;
        step();
        bus.coef_we    = 1'b0;
    endtask

    task automatic pulse_clr();
        bus.state_clr = 1'b1;
        step();
        bus.state_clr = 1'b0;
    endtask

    // Sends one sample with out_ready high; returns result, edges to out_valid,
    // and whether in_ready was seen high while busy.
    task automatic send_sample(input logic [31:0] x, input bit mac_wr,
                               output logic [31:0] y, output int lat, output bit rdy_seen);
        int n;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            step();
            n++;
        end
        bus.out_ready = 1'b1;
        bus.in_data   = x;
        bus.in_valid  = 1'b1;
        step();
        bus.in_valid  = 1'b0;
        lat      = 0;
        rdy_seen = 1'b0;
        while (!bus.out_valid && lat < 200) begin
            if (bus.in_ready) rdy_seen = 1'b1;
            if (mac_wr && lat == 2) begin
                bus.coef_we    = 1'b1;
                bus.coef_addr  = 4'd0;
                bus.coef_wdata = 32'd0;
            end else begin
                bus.coef_we = 1'b0;
            end
            step();
            lat++;
        end
        bus.coef_we = 1'b0;
        if (bus.in_ready) rdy_seen = 1'b1;
        y = bus.out_data;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        total++;
        if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %0b expected 0", bus.out_valid); end
        total++;
        if (bus.out_data !== 32'd0) begin bad++; $display("FAIL reset_out_data: got %0d expected 0", bus.out_data); end
        total++;
        if (bus.sat_flag !== 1'b0) begin bad++; $display("FAIL reset_sat_flag: got %0b expected 0", bus.sat_flag); end
        rst = 1'b0;
        step();
        total++;
        if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %0b expected 1", bus.in_ready); end
    endtask

    task automatic test_identity();
        logic [31:0] y; int lat; bit rs;
        send_sample(32'd1000, 1'b0, y, lat, rs);
        total++;
        if (y !== 32'd1000) begin bad++; $display("FAIL identity_data: got %0d expected 1000", y); end
        total++;
        if (lat !== 12) begin bad++; $display("FAIL identity_latency: got %0d expected 12", lat); end
        total++;
        if (rs !== 1'b0) begin bad++; $display("FAIL identity_in_ready_busy: got %0b expected 0", rs); end
    endtask

    task automatic test_coef_write();
        logic [31:0] y; int lat; bit rs;
        write_coef(4'd0, 32'h0008_0000);
        send_sample(32'd1000, 1'b0, y, lat, rs);
        total++;
        if (y !== 32'd500) begin bad++; $display("FAIL half_gain: got %0d expected 500", y); end
        send_sample(32'd1000, 1'b1, y, lat, rs);
        total++;
        if (y !== 32'd500) begin bad++; $display("FAIL mac_write_sample: got %0d expected 500", y); end
        send_sample(32'd1000, 1'b0, y, lat, rs);
        total++;
        if (y !== 32'd500) begin bad++; $display("FAIL mac_write_dropped: got %0d expected 500", y); end
        write_coef(4'd0, 32'h0010_0000);
    endtask

    task automatic test_backpressure();
        logic [31:0] held; int n; bit seen;
        bus.out_ready = 1'b0;
        bus.in_data   = 32'd1234;
        bus.in_valid  = 1'b1;
        step();
        bus.in_valid  = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 100) begin step(); n++; end
        held = bus.out_data;
        total++;
        if (held !== 32'd1234) begin bad++; $display("FAIL bp_data: got %0d expected 1234", held); end
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 32'd5;
            step();
            total++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== 32'd1234 || bus.in_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold: got valid=%0b data=%0d in_ready=%0b expected valid=1 data=1234 in_ready=0",
                         bus.out_valid, bus.out_data, bus.in_ready);
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        step();
        total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_release: got valid=%0b in_ready=%0b expected valid=0 in_ready=1", bus.out_valid, bus.in_ready);
        end
        seen = 1'b0;
        repeat (16) begin step(); if (bus.out_valid) seen = 1'b1; end
        total++;
        if (seen !== 1'b0) begin bad++; $display("FAIL bp_no_accept: got out_valid=1 expected 0"); end
    endtask

    task automatic test_saturation();
        logic [31:0] y; int lat; bit rs;
        logic [31:0] exp_y; logic exp_sat;
`ifdef IIR_BIQUAD_SAT_EN
        exp_y = 32'h7FFF_FFFF; exp_sat = 1'b1;
`else
        exp_y = 32'h0000_0000; exp_sat = 1'b0;
`endif
        pulse_clr();
        write_coef(4'd0, 32'h0040_0000);
        send_sample(32'h4000_0000, 1'b0, y, lat, rs);
        total++;
        if (y !== exp_y) begin bad++; $display("FAIL sat_data: got %0h expected %0h", y, exp_y); end
        total++;
        if (bus.sat_flag !== exp_sat) begin bad++; $display("FAIL sat_flag: got %0b expected %0b", bus.sat_flag, exp_sat); end
    endtask

    task automatic test_impulse();
        logic [31:0] y; int lat; bit rs;
        logic [31:0] exp_v [5];
        exp_v = '{32'd1024, 32'd512, 32'd256, 32'd128, 32'd64};
        write_coef(4'd0, 32'h0010_0000);
        write_coef(4'd3, 32'hFFF8_0000);
        pulse_clr();
        for (int i = 0; i < 5; i++) begin
            send_sample((i == 0) ? 32'd1024 : 32'd0, 1'b0, y, lat, rs);
            total++;
            if (y !== exp_v[i]) begin bad++; $display("FAIL impulse_%0d: got %0d expected %0d", i, y, exp_v[i]); end
        end
    endtask

    task automatic test_state_clr();
        logic [31:0] y; int lat; bit rs;
        bus.in_data   = 32'd5;
        bus.in_valid  = 1'b1;
        bus.state_clr = 1'b1;
        #1;
        total++;
        if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL clr_in_ready: got %0b expected 0", bus.in_ready); end
        step();
        bus.in_valid  = 1'b0;
        bus.state_clr = 1'b0;
        #1;
        total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL clr_no_accept: got in_ready=%0b valid=%0b expected 1 0", bus.in_ready, bus.out_valid);
        end
        total++;
        if (bus.sat_flag !== 1'b0) begin bad++; $display("FAIL clr_sat_flag: got %0b expected 0", bus.sat_flag); end
        send_sample(32'd0, 1'b0, y, lat, rs);
        total++;
        if (y !== 32'd0) begin bad++; $display("FAIL clr_zero: got %0d expected 0", y); end
        send_sample(32'd300, 1'b0, y, lat, rs);
        total++;
        if (y !== 32'd300) begin bad++; $display("FAIL clr_after: got %0d expected 300", y); end
    endtask

    task automatic test_rst_mid();
        logic [31:0] y; int lat; bit rs; bit seen;
        bus.out_ready = 1'b1;
        bus.in_data   = 32'd77;
        bus.in_valid  = 1'b1;
        step();
        bus.in_valid  = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
        total++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 32'd0 || bus.sat_flag !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_outputs: got valid=%0b data=%0d sat=%0b expected 0 0 0",
                     bus.out_valid, bus.out_data, bus.sat_flag);
        end
        rst  = 1'b0;
        seen = 1'b0;
        repeat (20) begin step(); if (bus.out_valid) seen = 1'b1; end
        total++;
        if (seen !== 1'b0) begin bad++; $display("FAIL rst_mid_no_output: got out_valid=1 expected 0"); end
        send_sample(32'd1000, 1'b0, y, lat, rs);
        total++;
        if (y !== 32'd1000) begin bad++; $display("FAIL rst_coef_identity: got %0d expected 1000", y); end
    endtask

    initial begin
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_data    = 32'd0;
        bus.out_ready  = 1'b1;
        bus.coef_we    = 1'b0;
        bus.coef_addr  = 4'd0;
        bus.coef_wdata = 32'd0;
        bus.state_clr  = 1'b0;
        step();
        test_reset();
        test_identity();
        test_coef_write();
        test_backpressure();
        test_saturation();
        test_impulse();
        test_state_clr();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
